// File: rtl/sram_read_sequencer.sv
// ---------------------------------------------------------------------------
// sram_read_sequencer
//
// Read-out side of the capture SRAM. After the write counter has filled the
// circular buffer and raised i_write_ready, this block reads back the last
// i_read_len samples, oldest first. The first address is
// i_last_wr_addr - i_read_len + 1, modulo 2^ADDR_W. Each sample is offered
// to the MCU with a valid/request handshake.
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         synchronous active-low reset
//   i_write_ready   capture complete (level)
//   i_last_wr_addr  final SRAM address written by the capture
//   i_read_len      number of samples to read back, 0 = none
//   i_start         one-cycle read-out request from the MCU
//   i_rd_req        MCU accepts the current o_data_out
//   i_sram_data     SRAM read data
//   o_sram_addr     SRAM read address
//   o_sram_oe_n     SRAM output enable, active-low
//   o_data_out      sample presented to the MCU
//   o_data_valid    o_data_out holds an unaccepted sample
//   o_busy          sequencer owns the SRAM (SETUP/WAIT/PRESENT)
//   o_read_done     every requested sample has been accepted (level)
// ---------------------------------------------------------------------------
module sram_read_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 8,
    parameter int SRAM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_write_ready,
    input  logic [ADDR_W-1:0] i_last_wr_addr,
    input  logic [ADDR_W-1:0] i_read_len,
    input  logic              i_start,
    input  logic              i_rd_req,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_oe_n,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_data_valid,
    output logic              o_busy,
    output logic              o_read_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETUP,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [3:0]        LAT_LAST = 4'(SRAM_LAT - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic [ADDR_W-1:0]  r_last_addr;
    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_remaining;
    logic [3:0]         r_lat_cnt;
    logic               r_oe_n;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;

    logic               w_latch;
    logic               w_busy;
    logic               w_abort;
    logic               w_lat_done;
    logic               w_accept;
    logic               w_last_sample;

    assign w_busy        = (r_state == S_SETUP) || (r_state == S_WAIT) ||
                           (r_state == S_PRESENT);
    // A falling i_write_ready while we own the SRAM means a new capture has
    // started and is overwriting the buffer, so the read-out is meaningless.
    assign w_abort       = w_busy && !i_write_ready;
    assign w_lat_done    = (r_lat_cnt == LAT_LAST);
    assign w_accept      = (r_state == S_PRESENT) && i_rd_req;
    assign w_last_sample = (r_remaining == ONE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode. IDLE and DONE share the start handling so a new
    // read-out can be launched straight from DONE; ARM finishes the same
    // decision once the capture completes. Length and end address are
    // latched on the edge that makes that decision.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        if (i_write_ready) begin
                            w_latch      = 1'b1;
                            w_next_state = (i_read_len != '0) ? S_SETUP : S_DONE;
                        end else begin
                            w_next_state = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (i_write_ready) begin
                        w_latch      = 1'b1;
                        w_next_state = (i_read_len != '0) ? S_SETUP : S_DONE;
                    end
                end
                S_SETUP: begin
                    w_next_state = S_WAIT;
                end
                S_WAIT: begin
                    if (w_lat_done) begin
                        w_next_state = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (i_rd_req) begin
                        w_next_state = w_last_sample ? S_DONE : S_WAIT;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Datapath: address generation, latency counting, sample capture and
    // the remaining-sample counter. Abort wins over everything including a
    // coincident accept, so the counter and address are left untouched.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_addr <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lat_cnt   <= '0;
            r_oe_n      <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            if (w_latch) begin
                r_last_addr <= i_last_wr_addr;
                r_len       <= i_read_len;
            end
            if (w_abort) begin
                r_oe_n  <= 1'b1;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_SETUP: begin
                        // Oldest sample of the window; wrap-around across
                        // address 0 is the circular buffer working normally.
                        r_addr      <= r_last_addr - r_len + ONE;
                        r_remaining <= r_len;
                        r_oe_n      <= 1'b0;
                        r_lat_cnt   <= '0;
                    end
                    S_WAIT: begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                        if (w_lat_done) begin
                            r_data  <= i_sram_data;
                            r_valid <= 1'b1;
                        end
                    end
                    S_PRESENT: begin
                        if (w_accept) begin
                            r_valid     <= 1'b0;
                            r_remaining <= r_remaining - ONE;
                            if (w_last_sample) begin
                                r_oe_n <= 1'b1;
                            end else begin
                                r_addr    <= r_addr + ONE;
                                r_lat_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        r_oe_n <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_sram_addr  = r_addr;
    assign o_sram_oe_n  = r_oe_n;
    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;
    assign o_busy       = w_busy;
    assign o_read_done  = (r_state == S_DONE);

endmodule

// File: doc/sram_read_sequencer.md
Name: sram_read_sequencer

Overview:
- Read-out side of the capture SRAM. The write counter fills the SRAM as a circular buffer and raises Write_Ready when the post-trigger window is complete.
- This block then reads back the last READ_LEN samples, oldest first, starting at LAST_WR_ADDR - READ_LEN + 1 (mod 2^ADDR_W).
- It presents each sample to the MCU interface with a valid/request handshake.
- It sits between the SRAM data bus and the MCU bus logic and owns SRAM_ADDR/SRAM_OE_N while BUSY.

Parameters:
- ADDR_W, 18, SRAM address width. Also the width of READ_LEN and the remaining counter.
- DATA_W, 8, SRAM data width.
- SRAM_LAT, 2, cycles from address/OE driven to SRAM_DATA valid. Legal range 1..15.

Ports:
- CLK  in  1  system clock. All logic is on the rising edge.
- RST  in  1  synchronous, active-low reset.
- WRITE_READY  in  1  capture complete (level, from the write counter).
- LAST_WR_ADDR  in  ADDR_W  final SRAM address written by the capture.
- READ_LEN  in  ADDR_W  number of samples to read. 0 means none.
- START  in  1  one-cycle request from the MCU to begin read-out.
- RD_REQ  in  1  MCU accepts the current DATA_OUT.
- SRAM_DATA  in  DATA_W  SRAM read data.
- SRAM_ADDR  out  ADDR_W  SRAM read address.
- SRAM_OE_N  out  1  SRAM output enable, active-low.
- DATA_OUT  out  DATA_W  sample presented to the MCU.
- DATA_VALID  out  1  DATA_OUT holds an unaccepted sample.
- BUSY  out  1  sequencer owns the SRAM.
- READ_DONE  out  1  all READ_LEN samples accepted. Level output.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous active-low and overrides everything.
- Reset values (RST=0 at an edge):
  - state IDLE; SRAM_ADDR=0; SRAM_OE_N=1; DATA_OUT=0.
  - DATA_VALID=0; BUSY=0; READ_DONE=0.
  - remaining=0; lat_cnt=0.
- Reset mid-readout aborts immediately. READ_DONE is not asserted.
- States:
  - IDLE:
    - START=1 and WRITE_READY=1: latch LAST_WR_ADDR and READ_LEN. Go to SETUP if READ_LEN≠0, else go to DONE.
    - START=1 and WRITE_READY=0: go to ARM. READ_LEN and LAST_WR_ADDR are latched when WRITE_READY is later seen.
  - ARM:
    - Wait for WRITE_READY=1, then behave as IDLE with START.
    - START is ignored while in ARM.
  - SETUP:
    - SRAM_ADDR <= latched LAST_WR_ADDR - READ_LEN + 1, ADDR_W-bit modulo (wrap-around is intentional).
    - remaining <= READ_LEN; SRAM_OE_N <= 0; lat_cnt <= 0. Next state WAIT.
  - WAIT:
    - lat_cnt increments each cycle.
    - When lat_cnt == SRAM_LAT-1: DATA_OUT <= SRAM_DATA, DATA_VALID <= 1, go to PRESENT.
  - PRESENT:
    - Hold DATA_OUT and DATA_VALID until RD_REQ=1 is sampled.
    - On that edge: DATA_VALID <= 0 and remaining <= remaining-1.
    - If remaining was 1: SRAM_OE_N <= 1, go to DONE.
    - Otherwise: SRAM_ADDR <= SRAM_ADDR+1 (wraps from 2^ADDR_W-1 to 0), lat_cnt <= 0, go to WAIT.
  - DONE:
    - READ_DONE=1; SRAM_OE_N=1.
    - START=1 clears READ_DONE and is handled exactly as in IDLE, in the same cycle.
- Output relationships:
  - BUSY=1 in SETUP, WAIT and PRESENT only.
  - RD_REQ outside PRESENT is ignored. It never decrements remaining.
  - START while BUSY or in ARM is ignored.
- Latency:
  - START edge → SETUP next cycle.
  - First DATA_VALID high SRAM_LAT+1 cycles after the SETUP cycle.
  - Each subsequent sample: DATA_VALID goes high SRAM_LAT cycles after the accepting edge.
  - Maximum throughput is one sample per SRAM_LAT+1 cycles.
- Abort: if WRITE_READY falls while BUSY (new capture started):
  - go to IDLE; SRAM_OE_N <= 1; DATA_VALID <= 0.
  - READ_DONE stays 0.
  - Abort takes priority over a simultaneous RD_REQ.
- Input stability: LAST_WR_ADDR and READ_LEN changes after latching have no effect.

Test Plan:
- Basic read, SRAM_LAT=2: RST high, WRITE_READY=1, LAST_WR_ADDR=100, READ_LEN=4, START pulse, SRAM model returns data=addr[7:0], RD_REQ held 1 → addresses 97,98,99,100; DATA_OUT 0x61,0x62,0x63,0x64; first DATA_VALID 3 cycles after SETUP; READ_DONE=1 after 4th accept; SRAM_OE_N=1 in DONE.
- Wrap-around: LAST_WR_ADDR=1, READ_LEN=4 → addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Backpressure: RD_REQ low for 10 cycles in PRESENT → DATA_VALID and DATA_OUT stable, SRAM_ADDR unchanged; single RD_REQ pulse → exactly one decrement.
- Edge cases:
  - READ_LEN=0 → DONE the cycle after START, SRAM_OE_N never low, DATA_VALID never high.
  - START with WRITE_READY=0 → ARM; WRITE_READY rises 5 cycles later → SETUP next cycle.
- Abort and reset:
  - WRITE_READY dropped during the 2nd sample → IDLE, READ_DONE=0, SRAM_OE_N=1.
  - RST=0 mid-WAIT → all outputs at their reset values on the next edge.
- Restart from DONE: START in DONE → READ_DONE clears and a new read begins; START while BUSY → ignored, address sequence unchanged.
